// File: rtl/std_mem_pkg.sv
// std_mem_pkg
//   Shared types and constants for the std_seq_mem_d1 memory slice.
//   - mem_state_t : controller state (IDLE, CLEAR)
//   - CLEAR_BIT   : bit value replicated across a word by the clear sweep
//   - CNT_W       : width of the clear-sweep counter for a given address width
package std_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } mem_state_t;

  // The clear sweep writes this bit into every position of a word.
  localparam logic CLEAR_BIT = 1'b0;

  // One extra bit keeps the sweep counter from wrapping when SIZE == 2**IDX_SIZE.
  function automatic int cnt_w(input int idx_size);
    return idx_size + 1;
  endfunction

endpackage

// File: rtl/std_seq_mem_d1_if.sv
// std_seq_mem_d1_if
//   Request/response bundle for std_seq_mem_d1.
//   master drives: addr0, write_data, write_en, read_en, clear
//   slave drives : read_data, done, busy, err
interface std_seq_mem_d1_if #(
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4
);

  logic [IDX_SIZE-1:0] addr0;
  logic [WIDTH-1:0]    write_data;
  logic                write_en;
  logic                read_en;
  logic                clear;
  logic [WIDTH-1:0]    read_data;
  logic                done;
  logic                busy;
  logic                err;

  modport master (
    output addr0, write_data, write_en, read_en, clear,
    input  read_data, done, busy, err
  );

  modport slave (
    input  addr0, write_data, write_en, read_en, clear,
    output read_data, done, busy, err
  );

endinterface

// File: rtl/std_seq_mem_clear_fsm.sv
// std_seq_mem_clear_fsm
//   Clear-sweep controller: walks addresses 0..SIZE-1, one per cycle,
//   after a clear request seen in IDLE. Only built with STD_SEQ_MEM_CLEAR_EN.
//   Ports:
//     clk, reset_n   : clock, asynchronous active-low reset
//     clear          : clear request (honoured only in IDLE)
//     idle           : controller is in IDLE and may accept requests
//     busy           : sweep in progress
//     sweep_en       : write CLEAR word to sweep_addr at this edge
//     sweep_addr     : word being cleared this cycle
//     sweep_last     : this cycle clears the final word
module std_seq_mem_clear_fsm
  import std_mem_pkg::*;
#(
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  output logic                idle,
  output logic                busy,
  output logic                sweep_en,
  output logic [IDX_SIZE-1:0] sweep_addr,
  output logic                sweep_last
);

  localparam int                CW   = cnt_w(IDX_SIZE);
  localparam logic [CW-1:0]     LAST = CW'(SIZE - 1);
  localparam logic [CW-1:0]     ONE  = CW'(1);

  mem_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sweep_en   = 1'b0;
    sweep_last = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        sweep_en = 1'b1;
        if (cnt == LAST) begin
          sweep_last = 1'b1;
          state_nxt  = IDLE;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign idle       = (state == IDLE);
  assign busy       = (state == CLEAR);
  assign sweep_addr = cnt[IDX_SIZE-1:0];

endmodule

// File: rtl/std_seq_mem_d1.sv
// std_seq_mem_d1
//   Single-port word memory with registered (1-cycle) read, done/err pulses
//   and an optional whole-array clear sweep.
//   Optional feature macro: STD_SEQ_MEM_CLEAR_EN (builds the clear sweep;
//   without it, clear is ignored and busy is tied low).
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     bus (slave)  : addr0, write_data, write_en, read_en, clear in;
//                    read_data, done, busy, err out
module std_seq_mem_d1
  import std_mem_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  std_seq_mem_d1_if.slave     bus
);

  localparam logic [IDX_SIZE:0] SIZE_W = (IDX_SIZE + 1)'(SIZE);

  logic [WIDTH-1:0]    mem [SIZE];
  logic                idle;
  logic                clr_take_p0;
  logic                req_vld_p0;
  logic                in_range_p0;
  logic                sweep_en;
  logic                sweep_last;
  logic [IDX_SIZE-1:0] sweep_addr;

`ifdef STD_SEQ_MEM_CLEAR_EN
  std_seq_mem_clear_fsm #(
    .SIZE     (SIZE),
    .IDX_SIZE (IDX_SIZE)
  ) u_clear_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (bus.clear),
    .idle       (idle),
    .busy       (bus.busy),
    .sweep_en   (sweep_en),
    .sweep_addr (sweep_addr),
    .sweep_last (sweep_last)
  );
  assign clr_take_p0 = idle & bus.clear;
`else
  logic unused_clear;
  assign unused_clear = bus.clear;
  assign idle         = 1'b1;
  assign bus.busy     = 1'b0;
  assign sweep_en     = 1'b0;
  assign sweep_last   = 1'b0;
  assign sweep_addr   = '0;
  assign clr_take_p0  = 1'b0;
`endif

  // A clear accepted in IDLE swallows any read/write presented with it.
  assign req_vld_p0  = idle & ~clr_take_p0 & (bus.write_en | bus.read_en);
  assign in_range_p0 = ({1'b0, bus.addr0} < SIZE_W);

  // ---- stage p0 -> p1: array update (memory contents are never reset) ----
  always_ff @(posedge clk) begin
    if (sweep_en) begin
      mem[sweep_addr] <= {WIDTH{CLEAR_BIT}};
    end else if (req_vld_p0 && bus.write_en && in_range_p0) begin
      mem[bus.addr0] <= bus.write_data;
    end
  end

  // ---- stage p0 -> p1: registered read result and status pulses ----
  // The read samples mem before this edge's write lands, so a same-cycle
  // read/write to one address returns the old word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.read_data <= '0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.done <= req_vld_p0 | sweep_last;
      bus.err  <= req_vld_p0 & ~in_range_p0;
      if (req_vld_p0 && bus.read_en) begin
        bus.read_data <= in_range_p0 ? mem[bus.addr0] : '0;
      end
    end
  end

endmodule

// File: tb/tb_std_seq_mem_d1.sv
// tb_std_seq_mem_d1
//   Drives two instances side by side with identical stimulus:
//   dut_a (SIZE=16, IDX_SIZE=4) and dut_b (SIZE=10, IDX_SIZE=4).
//   A behavioural model predicts each cycle's outputs; predictions are
//   queued when stimulus is applied and compared when the DUTs respond.
module tb_std_seq_mem_d1;

`ifdef STD_SEQ_MEM_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  addr0;
  logic [31:0] write_data;
  logic        write_en;
  logic        read_en;
  logic        clear;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  always #5 clk = ~clk;

  std_seq_mem_d1_if #(.WIDTH(32), .IDX_SIZE(4)) bus_a ();
  std_seq_mem_d1_if #(.WIDTH(32), .IDX_SIZE(4)) bus_b ();

  assign bus_a.addr0      = addr0;
  assign bus_a.write_data = write_data;
  assign bus_a.write_en   = write_en;
  assign bus_a.read_en    = read_en;
  assign bus_a.clear      = clear;
  assign bus_b.addr0      = addr0;
  assign bus_b.write_data = write_data;
  assign bus_b.write_en   = write_en;
  assign bus_b.read_en    = read_en;
  assign bus_b.clear      = clear;

  std_seq_mem_d1 #(.WIDTH(32), .SIZE(16), .IDX_SIZE(4)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  std_seq_mem_d1 #(.WIDTH(32), .SIZE(10), .IDX_SIZE(4)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  // ---------------- model state ----------------
  int          sz [2] = '{16, 10};
  logic [31:0] m_mem [2][16];
  logic [31:0] m_rd [2];
  bit          m_busy [2];
  int          m_cnt [2];

  typedef struct {
    logic [31:0] rd_a, rd_b;
    logic        done_a, done_b, err_a, err_b, busy_a, busy_b;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_rd[d]   = '0;
      m_busy[d] = 1'b0;
      m_cnt[d]  = 0;
    end
    sbq.delete();
  endtask

  // Outputs expected after the coming rising edge, for instance d.
  task automatic model_step(input int d, output logic [31:0] rd_e, output logic done_e,
                            output logic err_e, output logic busy_e);
    done_e = 1'b0;
    err_e  = 1'b0;
    if (m_busy[d]) begin
      m_mem[d][m_cnt[d]] = '0;
      if (m_cnt[d] == sz[d] - 1) begin
        m_busy[d] = 1'b0;
        done_e    = 1'b1;
      end else begin
        m_cnt[d]++;
      end
    end else if (clear && CLR_EN) begin
      m_busy[d] = 1'b1;
      m_cnt[d]  = 0;
    end else if (write_en || read_en) begin
      done_e = 1'b1;
      if (int'(addr0) >= sz[d]) begin
        err_e = 1'b1;
        if (read_en) m_rd[d] = '0;
      end else begin
        if (read_en)  m_rd[d] = m_mem[d][addr0];
        if (write_en) m_mem[d][addr0] = write_data;
      end
    end
    rd_e   = m_rd[d];
    busy_e = m_busy[d];
  endtask

  // Apply current inputs for one clock; compare on the following falling edge.
  task automatic cyc();
    exp_t        e;
    exp_t        g;
    logic [31:0] r;
    logic        dn, er, bs;
    model_step(0, r, dn, er, bs);
    e.rd_a = r; e.done_a = dn; e.err_a = er; e.busy_a = bs;
    model_step(1, r, dn, er, bs);
    e.rd_b = r; e.done_b = dn; e.err_b = er; e.busy_b = bs;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    g = sbq.pop_front();
    chk({phase, ".rd_a"},   bus_a.read_data, g.rd_a);
    chk({phase, ".done_a"}, 32'(bus_a.done), 32'(g.done_a));
    chk({phase, ".err_a"},  32'(bus_a.err),  32'(g.err_a));
    chk({phase, ".busy_a"}, 32'(bus_a.busy), 32'(g.busy_a));
    chk({phase, ".rd_b"},   bus_b.read_data, g.rd_b);
    chk({phase, ".done_b"}, 32'(bus_b.done), 32'(g.done_b));
    chk({phase, ".err_b"},  32'(bus_b.err),  32'(g.err_b));
    chk({phase, ".busy_b"}, 32'(bus_b.busy), 32'(g.busy_b));
  endtask

  task automatic req(input logic we, input logic re, input logic clr,
                     input logic [3:0] a, input logic [31:0] d);
    write_en   = we;
    read_en    = re;
    clear      = clr;
    addr0      = a;
    write_data = d;
    cyc();
    write_en = 1'b0;
    read_en  = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, ".rd_a"},   bus_a.read_data, 32'h0);
    chk({tag, ".done_a"}, 32'(bus_a.done), 32'h0);
    chk({tag, ".err_a"},  32'(bus_a.err),  32'h0);
    chk({tag, ".busy_a"}, 32'(bus_a.busy), 32'h0);
    chk({tag, ".rd_b"},   bus_b.read_data, 32'h0);
    chk({tag, ".done_b"}, 32'(bus_b.done), 32'h0);
    chk({tag, ".err_b"},  32'(bus_b.err),  32'h0);
    chk({tag, ".busy_b"}, 32'(bus_b.busy), 32'h0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) req(1'b0, 1'b1, 1'b0, 4'(i), 32'h0);
  endtask

  task automatic fill_all(input logic [31:0] base);
    for (int i = 0; i < 16; i++) req(1'b1, 1'b0, 1'b0, 4'(i), base + 32'(i) * 32'h0001_0101);
  endtask

  initial begin
    reset_n = 1'b0; addr0 = '0; write_data = '0;
    write_en = 1'b0; read_en = 1'b0; clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;

    phase = "wr_rd";
    req(1'b1, 1'b0, 1'b0, 4'd3, 32'hDEAD_BEEF);
    req(1'b0, 1'b1, 1'b0, 4'd3, 32'h0);
    req(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    req(1'b1, 1'b0, 1'b0, 4'd3, 32'h1234_5678);  // read_data must hold

    phase = "fill";
    fill_all(32'hA500_0001);

    phase = "rbw";
    req(1'b1, 1'b0, 1'b0, 4'd5, 32'h11);
    req(1'b1, 1'b1, 1'b0, 4'd5, 32'h22);
    req(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    req(1'b0, 1'b1, 1'b0, 4'd5, 32'h0);

    phase = "range";
    req(1'b0, 1'b1, 1'b0, 4'd12, 32'h0);
    req(1'b1, 1'b0, 1'b0, 4'd12, 32'hCAFE_F00D);
    req(1'b1, 1'b1, 1'b0, 4'd15, 32'h5555_AAAA);
    read_all();

    phase = "rand";
    for (int i = 0; i < 40; i++)
      req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
          4'($urandom_range(0, 15)), $urandom());

    phase = "sweep";
    fill_all(32'h3C00_0010);
    req(1'b0, 1'b1, 1'b1, 4'd2, 32'h0);          // clear wins over read
    for (int k = 0; k < 17; k++) begin
      if (k % 3 == 0) req(1'b1, 1'b0, 1'b0, 4'(k), 32'hBAD0_0000 | 32'(k));
      else if (k == 7) req(1'b0, 1'b1, 1'b1, 4'd1, 32'h0);
      else if (k == 8) req(1'b0, 1'b1, 1'b0, 4'd4, 32'h0);
      else req(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    end
    phase = "post_sweep";
    read_all();

    phase = "abort";
    fill_all(32'h7100_0100);
    req(1'b0, 1'b1, 1'b0, 4'd7, 32'h0);          // non-zero read_data before reset
    req(1'b0, 1'b0, 1'b1, 4'd0, 32'h0);
    for (int k = 0; k < 6; k++) req(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("abort_async");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("abort_held");
    reset_n = 1'b1;
    phase = "post_abort";
    read_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/std_seq_mem_d1.md
STD_SEQ_MEM_D1 -- requirements
Module: std_seq_mem_d1

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter SIZE, default 16, number of words.
REQ-003 SHALL have parameter IDX_SIZE, default 4, address width in bits.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have addr0  input  IDX_SIZE  word address for read/write.
REQ-007 SHALL have write_data  input  WIDTH  data to store.
REQ-008 SHALL have write_en  input  1  write request, sampled at posedge.
REQ-009 SHALL have read_en  input  1  read request, sampled at posedge.
REQ-010 SHALL have clear  input  1  request to zero the entire array.
REQ-011 SHALL have read_data  output  WIDTH  registered read result.
REQ-012 SHALL have done  output  1  one-cycle completion pulse.
REQ-013 SHALL have busy  output  1  high while a clear sweep runs.
REQ-014 SHALL have err  output  1  one-cycle pulse, out-of-range access.

Function
REQ-015 SHALL implement states IDLE and CLEAR; IDLE->CLEAR on clear=1, CLEAR->IDLE after final address is written.
REQ-016 In IDLE, write_en=1 with addr0<SIZE SHALL write write_data to mem[addr0] at that posedge and assert done for the next cycle.
REQ-017 In IDLE, read_en=1 with addr0<SIZE SHALL load read_data with mem[addr0] at that posedge (1-cycle latency) and assert done for the same next cycle.
REQ-018 read_data SHALL hold its value until the next accepted read; writes SHALL NOT change it.
REQ-019 write_en and read_en together on the same address SHALL perform the write and return the pre-write value (read-before-write), with a single done pulse.
REQ-020 addr0>=SIZE with write_en or read_en SHALL suppress the write, load read_data with 0 if reading, and pulse err and done together.
REQ-021 clear=1 in IDLE SHALL take priority over simultaneous read_en/write_en, which are dropped without done.
REQ-022 CLEAR SHALL zero one word per cycle, addresses 0..SIZE-1 ascending, SIZE cycles total, with busy=1 throughout.
REQ-023 On the final CLEAR cycle the block SHALL return to IDLE, assert done for one cycle, and deassert busy.
REQ-024 read_en, write_en and clear asserted during CLEAR SHALL be ignored: no done, no err, and no memory or read_data change.
REQ-025 The clear counter SHALL be IDX_SIZE+1 bits wide so SIZE=2**IDX_SIZE terminates without wrap.

Reset
REQ-026 reset_n=0 SHALL immediately force state=IDLE, counter=0, read_data=0, done=0, busy=0, err=0.
REQ-027 Memory contents SHALL NOT be reset; reset during CLEAR SHALL abort the sweep, leaving it partially cleared, with no done.

Configuration
REQ-028 Macro STD_SEQ_MEM_CLEAR_EN defined SHALL compile in the CLEAR state, counter and clear behaviour.
REQ-029 Without STD_SEQ_MEM_CLEAR_EN, the clear port SHALL remain present but be ignored, busy SHALL be tied 0, and the block SHALL stay in IDLE.

Structure
REQ-030 Package std_mem_pkg SHALL hold the state enum typedef (IDLE, CLEAR) and the clear-value constant (all-zero).
REQ-031 The clear sweep SHALL be sub-module std_seq_mem_clear_fsm (state, counter, busy, sweep address/enable), instantiated only under STD_SEQ_MEM_CLEAR_EN.

Verification
REQ-032 Write 0xDEADBEEF to addr 3, then read addr 3 -> done after each request; read_data=0xDEADBEEF one cycle after read_en.
REQ-033 Memory holds 0x11 at addr 5; write 0x22 and read addr 5 in the same cycle -> read_data=0x11, one done pulse; a later read returns 0x22.
REQ-034 SIZE=10, IDX_SIZE=4, read addr 12 -> read_data=0, err=1 and done=1 for one cycle; a write to addr 12 leaves all 10 words unchanged.
REQ-035 Fill all 16 words, pulse clear -> busy=1 for 16 cycles; writes issued mid-sweep are ignored; done once at the end; all reads return 0.
REQ-036 Pull reset_n low at sweep cycle 6 -> outputs go 0 asynchronously; words 0..5 read 0, words 6..15 keep their old data; no done.
